// File: rtl/scoreboard_button_ctrl.sv
// Debounced pushbutton front end issuing one-cycle inc/dec/erase commands to the score counter.
// Define SCOREBOARD_AUTOREPEAT_EN to enable hold-to-auto-repeat for up/down.
module scoreboard_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_DELAY    = 64,
   parameter int unsigned REPEAT_PERIOD   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up_i,
   input  logic       btn_down_i,
   input  logic       btn_clr_i,
   output logic       inc_o,
   output logic       dec_o,
   output logic       erase_o,
   output logic [2:0] btn_state_o
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   // Bit order everywhere is {clr, down, up}.
   logic [2:0] raw;
   logic [2:0] sync1_q, sync2_q;
   logic [2:0] deb_q, deb_d;
   logic [2:0][DbW-1:0] db_cnt_q, db_cnt_d;

   assign raw = {btn_clr_i, btn_down_i, btn_up_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      for (int b = 0; b < 3; b++) begin
         if (sync2_q[b] != deb_q[b]) begin
            if (db_cnt_q[b] == DbLast) begin
               deb_d[b]    = sync2_q[b];
               db_cnt_d[b] = '0;
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + 1'b1;
            end
         end else begin
            db_cnt_d[b] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q    <= '0;
         db_cnt_q <= '0;
      end else begin
         deb_q    <= deb_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   logic up, down, clr;
   assign up   = deb_q[0];
   assign down = deb_q[1];
   assign clr  = deb_q[2];

`ifdef SCOREBOARD_AUTOREPEAT_EN
   localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned TmrW   = $clog2(RptMax);
   localparam logic [TmrW-1:0] DelayLast  = TmrW'(REPEAT_DELAY - 1);
   localparam logic [TmrW-1:0] PeriodLast = TmrW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {StIdle, StHold, StRepeat, StWaitRel} state_e;

   logic            dir_q, dir_d;     // 1: down, 0: up
   logic [TmrW-1:0] timer_q, timer_d;
   logic            abort;

   // Leave the hold as soon as the latched button is not the only one pressed.
   assign abort = dir_q ? (~down | up | clr) : (~up | down | clr);
`else
   typedef enum logic [0:0] {StIdle, StWaitRel} state_e;

   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   state_e state_q, state_d;
   logic   inc_q, inc_d;
   logic   dec_q, dec_d;
   logic   erase_q, erase_d;

   always_comb begin
      state_d = state_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      erase_d = 1'b0;
`ifdef SCOREBOARD_AUTOREPEAT_EN
      dir_d   = dir_q;
      timer_d = timer_q;
`endif
      case (state_q)
         StIdle: begin
            if (clr) begin
               erase_d = 1'b1;
               state_d = StWaitRel;
            end else if (up ^ down) begin
               inc_d = up;
               dec_d = down;
`ifdef SCOREBOARD_AUTOREPEAT_EN
               dir_d   = down;
               timer_d = '0;
               state_d = StHold;
`else
               state_d = StWaitRel;
`endif
            end else if (up & down) begin
               state_d = StWaitRel;
            end
         end
`ifdef SCOREBOARD_AUTOREPEAT_EN
         StHold, StRepeat: begin
            if (abort) begin
               state_d = StWaitRel;
            end else if (timer_q == ((state_q == StHold) ? DelayLast : PeriodLast)) begin
               inc_d   = ~dir_q;
               dec_d   = dir_q;
               timer_d = '0;
               state_d = StRepeat;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
`endif
         StWaitRel: begin
            if (deb_q == 3'b000) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         erase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         erase_q <= erase_d;
      end
   end

`ifdef SCOREBOARD_AUTOREPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         dir_q   <= dir_d;
         timer_q <= timer_d;
      end
   end
`endif

   assign inc_o       = inc_q;
   assign dec_o       = dec_q;
   assign erase_o     = erase_q;
   assign btn_state_o = deb_q;

endmodule

// File: tb/tb_scoreboard_button_ctrl.sv
// Bench for scoreboard_button_ctrl: per-cycle comparison against a behavioural model plus
// directed pulse-timing checks. Honours SCOREBOARD_AUTOREPEAT_EN like the design.
module tb_scoreboard_button_ctrl;

   localparam int unsigned Deb = 4;
   localparam int unsigned Rd  = 8;
   localparam int unsigned Rp  = 4;
`ifdef SCOREBOARD_AUTOREPEAT_EN
   localparam bit AutoRep = 1'b1;
`else
   localparam bit AutoRep = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up_i = 1'b0;
   logic       btn_down_i = 1'b0;
   logic       btn_clr_i = 1'b0;
   logic       inc_o, dec_o, erase_o;
   logic [2:0] btn_state_o;

   scoreboard_button_ctrl #(
      .DEBOUNCE_CYCLES (Deb),
      .REPEAT_DELAY    (Rd),
      .REPEAT_PERIOD   (Rp)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_up_i    (btn_up_i),
      .btn_down_i  (btn_down_i),
      .btn_clr_i   (btn_clr_i),
      .inc_o       (inc_o),
      .dec_o       (dec_o),
      .erase_o     (erase_o),
      .btn_state_o (btn_state_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: sync delay, run-length debounce, and pulses from the age of a hold.
   logic [2:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
   int         m_run [3];
   bit         m_locked = 1'b0;
   int         m_dir = 0;   // 0 none, 1 up, 2 down
   int         m_age = 0;
   bit         e_inc = 1'b0, e_dec = 1'b0, e_erase = 1'b0;

   initial begin
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int b = 0; b < 3; b++) m_run[b] = 0;
            m_locked = 1'b0; m_dir = 0; m_age = 0;
            e_inc = 1'b0; e_dec = 1'b0; e_erase = 1'b0;
         end else begin
            e_inc = 1'b0; e_dec = 1'b0; e_erase = 1'b0;
            if (m_locked) begin
               if (m_deb == 3'b000) m_locked = 1'b0;
            end
`ifdef SCOREBOARD_AUTOREPEAT_EN
            else if (m_dir != 0) begin
               if (m_deb != ((m_dir == 1) ? 3'b001 : 3'b010)) begin
                  m_dir = 0;
                  m_locked = 1'b1;
               end else begin
                  m_age++;
                  if (m_age >= Rd && ((m_age - Rd) % Rp) == 0) begin
                     e_inc = (m_dir == 1);
                     e_dec = (m_dir == 2);
                  end
               end
            end
`endif
            else begin
               if (m_deb[2]) begin
                  e_erase = 1'b1;
                  m_locked = 1'b1;
               end else if (m_deb[1:0] == 2'b01 || m_deb[1:0] == 2'b10) begin
                  e_inc = m_deb[0];
                  e_dec = m_deb[1];
`ifdef SCOREBOARD_AUTOREPEAT_EN
                  m_dir = m_deb[0] ? 1 : 2;
                  m_age = 0;
`else
                  m_locked = 1'b1;
`endif
               end else if (m_deb[1:0] == 2'b11) begin
                  m_locked = 1'b1;
               end
            end
            for (int b = 0; b < 3; b++) begin
               if (m_s2[b] != m_deb[b]) begin
                  m_run[b]++;
                  if (m_run[b] == Deb) begin
                     m_deb[b] = m_s2[b];
                     m_run[b] = 0;
                  end
               end else begin
                  m_run[b] = 0;
               end
            end
            m_s2 = m_s1;
            m_s1 = {btn_clr_i, btn_down_i, btn_up_i};
         end
      end
   end

   // Per-cycle compare and pulse logging; a logged value is the edge after which the pulse is high.
   int         inc_log[$];
   int         dec_log[$];
   int         erase_log[$];
   logic [2:0] state_or = '0;

   always @(negedge clk) begin
      chk("inc_o", int'(inc_o), int'(e_inc));
      chk("dec_o", int'(dec_o), int'(e_dec));
      chk("erase_o", int'(erase_o), int'(e_erase));
      chk("btn_state_o", int'(btn_state_o), int'(m_deb));
      chk("one_hot", int'($countones({inc_o, dec_o, erase_o}) <= 1), 1);
      if (rst_n) begin
         if (inc_o) inc_log.push_back(cyc);
         if (dec_o) dec_log.push_back(cyc);
         if (erase_o) erase_log.push_back(cyc);
         state_or = state_or | btn_state_o;
      end
   end

   task automatic clear_logs();
      inc_log.delete();
      dec_log.delete();
      erase_log.delete();
      state_or = '0;
   endtask

   function automatic int first(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   int k;
   int bounce[5] = '{1, 0, 1, 1, 0};

   initial begin
      // Reset, then idle
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      clear_logs();
      repeat (20) @(negedge clk);
      chk("idle_inc_cnt", inc_log.size(), 0);
      chk("idle_dec_cnt", dec_log.size(), 0);
      chk("idle_erase_cnt", erase_log.size(), 0);
      chk("idle_state", int'(state_or), 0);

      // Hold up for 40 samples
      clear_logs();
      k = cyc + 1;
      btn_up_i = 1'b1;
      repeat (40) @(negedge clk);
      btn_up_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("up_first", first(inc_log), k + 6);
      chk("up_count", inc_log.size(), AutoRep ? 9 : 1);
`ifdef SCOREBOARD_AUTOREPEAT_EN
      chk("up_rep1", (inc_log.size() > 1) ? inc_log[1] : -1, k + 14);
      chk("up_rep2", (inc_log.size() > 2) ? inc_log[2] : -1, k + 18);
      chk("up_rep3", (inc_log.size() > 3) ? inc_log[3] : -1, k + 22);
`endif
      chk("up_dec_cnt", dec_log.size(), 0);
      chk("up_erase_cnt", erase_log.size(), 0);

      // Bouncy down then a stable 10-cycle press
      clear_logs();
      for (int i = 0; i < 5; i++) begin
         btn_down_i = bounce[i][0];
         @(negedge clk);
      end
      k = cyc + 1;
      btn_down_i = 1'b1;
      repeat (10) @(negedge clk);
      btn_down_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("bounce_first", first(dec_log), k + 6);
      chk("bounce_count", dec_log.size(), AutoRep ? 2 : 1);
      chk("bounce_inc_cnt", inc_log.size(), 0);

      // Short glitches are rejected
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         btn_down_i = 1'b1;
         repeat (3) @(negedge clk);
         btn_down_i = 1'b0;
         repeat (6) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("glitch_dec_cnt", dec_log.size(), 0);
      chk("glitch_state", int'(state_or), 0);

      // Up and down together, then clear held long
      clear_logs();
      btn_up_i = 1'b1;
      btn_down_i = 1'b1;
      repeat (20) @(negedge clk);
      chk("both_state", int'(btn_state_o), 3);
      btn_up_i = 1'b0;
      btn_down_i = 1'b0;
      repeat (15) @(negedge clk);
      chk("both_inc_cnt", inc_log.size(), 0);
      chk("both_dec_cnt", dec_log.size(), 0);
      clear_logs();
      k = cyc + 1;
      btn_clr_i = 1'b1;
      repeat (100) @(negedge clk);
      btn_clr_i = 1'b0;
      repeat (15) @(negedge clk);
      chk("clr_count", erase_log.size(), 1);
      chk("clr_first", first(erase_log), k + 6);
      chk("clr_inc_cnt", inc_log.size(), 0);

      // Reset while up is held mid-repeat
      clear_logs();
      k = cyc + 1;
      btn_up_i = 1'b1;
      repeat (23) @(negedge clk);
      chk("pre_rst_inc", int'(inc_o), AutoRep ? 1 : 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_inc", int'(inc_o), 0);
      chk("rst_async_state", int'(btn_state_o), 0);
      clear_logs();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      k = cyc + 1;
      repeat (25) @(negedge clk);
      btn_up_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_first", first(inc_log), k + 6);
      chk("post_rst_count", inc_log.size(), AutoRep ? 6 : 1);
`ifdef SCOREBOARD_AUTOREPEAT_EN
      chk("post_rst_rep1", (inc_log.size() > 1) ? inc_log[1] : -1, k + 14);
`endif
      chk("post_rst_erase", erase_log.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scoreboard_button_ctrl.md
# scoreboard_button_ctrl

Front-end command generator for the scoreboard: synchronizes and debounces three raw pushbuttons (up, down, clear) and issues single-cycle, mutually exclusive `inc`/`dec`/`erase` command pulses to the 2-digit BCD score counter. It is the initiator side of the counter's command interface. It also provides optional hold-to-auto-repeat for up/down.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive cycles a synchronized level must differ from the debounced level before the debounced level changes; must be ≥ 2.
- `REPEAT_DELAY`, default 64: cycles from the first pulse of a held up/down to the first repeat pulse; must be ≥ 2.
- `REPEAT_PERIOD`, default 16: cycles between later repeat pulses; must be ≥ 2.
- `clk  input  1` — single clock; all flops on its rising edge.
- `rst_n  input  1` — asynchronous, active-low reset.
- `btn_up_i  input  1` — raw up button, active-high, asynchronous to `clk`.
- `btn_down_i  input  1` — raw down button, active-high, asynchronous.
- `btn_clr_i  input  1` — raw clear button, active-high, asynchronous.
- `inc_o  output  1` — one-cycle increment command.
- `dec_o  output  1` — one-cycle decrement command.
- `erase_o  output  1` — one-cycle erase command.
- `btn_state_o  output  3` — debounced levels `{clr, down, up}`.

## Operation
- Reset state: all outputs 0, FSM in IDLE, synchronizer flops 0, debounced levels 0, all counters 0.
- Synchronizer: each raw input passes through a 2-flop synchronizer.
- Debounce, per button:
  - When the synchronized level differs from the debounced level, the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - Whenever the two levels are equal, the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- FSM states: IDLE, HOLD, REPEAT, WAIT_REL. It acts on debounced levels only.
- IDLE transitions:
  - clr=1: pulse `erase_o`, go to WAIT_REL. Clear has priority over up/down.
  - Exactly one of up/down = 1: pulse `inc_o` or `dec_o`, latch the direction, clear the timer, go to HOLD.
  - up=1 and down=1 (clr=0): no pulse, go to WAIT_REL.
- HOLD transitions:
  - Abort to WAIT_REL with no pulse if the latched button is released, the other direction is pressed, or clr is pressed.
  - Otherwise the timer increments. When timer = `REPEAT_DELAY-1`, pulse the latched direction, clear the timer, go to REPEAT.
- REPEAT transitions:
  - Same abort conditions as HOLD.
  - When timer = `REPEAT_PERIOD-1`, pulse again and clear the timer.
- WAIT_REL: no pulses. Go to IDLE when all three debounced levels are 0.
  - A clear pressed during HOLD/REPEAT is therefore not executed; the user must release all buttons and press clear again.
- Output rules:
  - Outputs are registered.
  - At most one of `inc_o`/`dec_o`/`erase_o` is high in any cycle.
  - Every pulse lasts exactly one cycle.
- Timer width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`. The timer never wraps; it is cleared on every pulse and on every entry to HOLD.

## Timing
- Press latency: let edge k be the first edge that samples a raw press.
  - The debounced level rises at edge k+1+`DEBOUNCE_CYCLES`.
  - The command pulse is high for the one cycle following edge k+2+`DEBOUNCE_CYCLES`.
- Release latency: the debounced level falls `DEBOUNCE_CYCLES`+1 edges after the first edge that samples a raw release.
- Auto-repeat timing:
  - First repeat pulse comes `REPEAT_DELAY` edges after the initial pulse.
  - Later repeat pulses come every `REPEAT_PERIOD` edges.
- Glitch rejection: a raw pulse or bounce shorter than `DEBOUNCE_CYCLES` cycles after synchronization produces no debounced change and no command.
- Reset mid-operation:
  - Outputs go to 0 immediately (asynchronous). No pulse may be emitted in the cycle reset deasserts.
  - A button still held after reset is treated as a new press: one pulse after the full debounce latency.

## Configuration
- `SCOREBOARD_AUTOREPEAT_EN` defined: HOLD, REPEAT and the repeat timer are present, behaving as described above.
- `SCOREBOARD_AUTOREPEAT_EN` undefined:
  - HOLD, REPEAT and the timer are compiled out. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.
  - IDLE goes straight to WAIT_REL after an up/down pulse, so each press yields exactly one command however long it is held.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4.
- Reset then idle 20 cycles: all outputs and `btn_state_o` stay 0.
- Hold `btn_up_i` from edge k for 40 cycles, autorepeat on: `inc_o` pulses after edges k+6, k+14, k+18, k+22, …. Pulses stop within 6 edges of release. `dec_o`/`erase_o` stay 0.
- Same stimulus with the macro undefined: exactly one `inc_o` pulse, after edge k+6.
- Bouncy `btn_down_i` (1,0,1,1,0 over 5 cycles, then stable 1 for 10 cycles, then 0): exactly one `dec_o`. Shorter 3-cycle glitches produce none.
- Press up and down together for 20 cycles: no pulses. Then press and hold `btn_clr_i` for 100 cycles: exactly one `erase_o`.
- Assert `rst_n`=0 during REPEAT while up is held, release reset after 3 cycles: no pulse during reset. One `inc_o` pulse 6 edges after the first post-reset sample, then repeats resume.
